signed_sevenseg_scan: RTL
=========================

# signed_sevenseg_scan

Parametrised signed-binary-to-seven-segment display driver. Accepts a WIDTH-bit two's-complement value on a load strobe, converts its magnitude to BCD with a sequential double-dabble engine, and drives DIGITS time-multiplexed active-low seven-segment digits, with a minus sign on a sign digit. It is the board-level display front end for register and ALU result readout.

## Interface

- WIDTH, 8: input value width, two's complement; range 2 to 16.
- DIGITS, 4: physical digits, including the sign digit; must be at least 1 + the number of decimal digits of 2^(WIDTH-1).
- SCAN_DIV, 1000: clock cycles each digit stays enabled; must be at least 1.
- clk  in  1  single clock; all state is updated on the rising edge.
- rst  in  1  synchronous, active-high reset.
- value  in  WIDTH  signed value to display; sampled only when load is accepted.
- load  in  1  request to convert value; accepted only while busy=0.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse when the new value is latched into the display.
- seg  out  7  active-low segments {a,b,c,d,e,f,g}; a is the MSB.
- an  out  DIGITS  active-low one-hot digit enable; bit 0 is the rightmost digit.

## Operation

- Segment codes for 0 to 9: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100.
- Minus sign is 1111110 (segment g only); blank is 1111111.
- FSM states:
  - IDLE: load=1 captures sign = value[WIDTH-1] and mag = |value| as WIDTH-bit unsigned, clears the BCD register, sets count=0, then goes to CONV.
  - CONV: each cycle adds 3 to every BCD nibble ≥5, then shifts {bcd, mag} left by 1. After WIDTH iterations it goes to LATCH.
  - LATCH: copies the BCD digits and the sign into the display registers, pulses done, then returns to IDLE.
- The most negative input, -2^(WIDTH-1), has a magnitude that fits unsigned in WIDTH bits and must display correctly.
- The BCD register is 4*(DIGITS-1) bits wide.
- load in CONV or LATCH is ignored; there is no queueing.
- Sign digit:
  - Default: the sign is always on digit DIGITS-1 and is blank for non-negative values.
  - All magnitude digits are shown, including leading zeros.
- Scan:
  - A prescaler counts 0 to SCAN_DIV-1.
  - At terminal count the digit index advances as (idx+1) mod DIGITS.
  - seg and an are registered together, so they change on the same edge.
  - A display-register update does not reset the scan position.

## Timing

- Reset values: busy=0, done=0, seg=1111111, an = all ones except bit 0 cleared (digit 0 enabled), display registers all blank, prescaler=0, idx=0, FSM in IDLE.
- Load accepted at edge k:
  - busy=1 from k+1.
  - CONV iterations occur on edges k+1 to k+WIDTH.
  - LATCH occurs at edge k+WIDTH+1.
- done is high for exactly one cycle after edge k+WIDTH+1; busy is low in that same cycle.
- A new load is accepted in the done cycle. Back-to-back conversions therefore take WIDTH+2 cycles each.
- seg shows a new value no later than the next seg register update after the LATCH edge.
- rst asserted mid-conversion:
  - Aborts the conversion with no done pulse.
  - Forces all reset values, including a blank display.

## Configuration

- LEADING_ZERO_BLANK_EN defined:
  - Leading zero digits are blanked; digit 0 is never blanked, so a value of 0 shows a single 0.
  - The minus sign occupies the digit immediately left of the most significant nonzero digit.
  - All digits further left are blank.
- LEADING_ZERO_BLANK_EN undefined: the default behaviour in Operation applies.
- Conversion latency is identical in both builds.

## Structure

- Package signed_sevenseg_pkg holds:
  - SEG_MINUS and SEG_BLANK constants.
  - A digit-to-segment decode function.
  - The FSM state enum (IDLE, CONV, LATCH).
- Sub-module bin2bcd_seq contains the double-dabble engine: mag, bcd, count, and the start/done handshake.
- The top level holds the display registers, the blanking/sign placement, and the scan logic.

## Test plan

All scenarios use WIDTH=8, DIGITS=4, SCAN_DIV=4.

- Reset: assert rst for 2 cycles -> seg=1111111, an=1110, busy=0, done=0.
- Scan order: with no load applied -> an steps 1110, 1101, 1011, 0111, 1110, holding each pattern exactly 4 cycles.
- Most negative value: load 8'h80 -> done exactly 10 cycles after the load edge. Digits 3..0 show 1111110, 1001111, 0010010, 0000000 (-128).
- Small positive and negative values:
  - load 8'h05, macro off -> digits 3..0 show blank, 0000001, 0000001, 0100100.
  - load 8'h05, macro on -> digits 3..0 show blank, blank, blank, 0100100.
  - load 8'hFB, macro on -> digit 1 shows 1111110 and digit 0 shows 0100100.
- Load while busy: load 8'h7F, then load 8'h00 two cycles later -> a single done pulse, and the display shows 127.
- Reset mid-conversion: load 8'h2A, then assert rst 4 cycles later -> no done pulse, busy=0, and the display returns to blank.

Source files
------------

// File: rtl/signed_sevenseg_pkg.sv
// ============================================================================
// signed_sevenseg_pkg: segment constants, digit decode and FSM state enum.  Rev 1.0
// ============================================================================
`default_nettype none

package signed_sevenseg_pkg;

  localparam logic [6:0] SEG_MINUS = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    LATCH = 2'd2
  } state_t;

  // Active-low {a,b,c,d,e,f,g}; non-decimal nibbles show blank.
  function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    digit_to_seg = 7'b0000001;
      4'd1:    digit_to_seg = 7'b1001111;
      4'd2:    digit_to_seg = 7'b0010010;
      4'd3:    digit_to_seg = 7'b0000110;
      4'd4:    digit_to_seg = 7'b1001100;
      4'd5:    digit_to_seg = 7'b0100100;
      4'd6:    digit_to_seg = 7'b0100000;
      4'd7:    digit_to_seg = 7'b0001111;
      4'd8:    digit_to_seg = 7'b0000000;
      4'd9:    digit_to_seg = 7'b0000100;
      default: digit_to_seg = SEG_BLANK;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// ============================================================================
// bin2bcd_seq: sequential double-dabble converter, one bit per clock.  Rev 1.0
// ============================================================================
`default_nettype none

module bin2bcd_seq
  import signed_sevenseg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BCD_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] mag_in,
  output logic             busy,
  output logic             latch,
  output logic [BCD_W-1:0] bcd
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   mag;
  logic [CNT_W-1:0]   count;
  logic [BCD_W-1:0]   adj;

  always_comb begin
    adj = bcd;
    for (int n = 0; n < BCD_W / 4; n++) begin
      if (bcd[4*n +: 4] >= 4'd5) adj[4*n +: 4] = bcd[4*n +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CONV;
      CONV:    if (count == CNT_W'(WIDTH - 1)) state_next = LATCH;
      LATCH:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy  = (state != IDLE);
  assign latch = (state == LATCH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mag   <= '0;
      bcd   <= '0;
      count <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            mag   <= mag_in;
            bcd   <= '0;
            count <= '0;
          end
        end
        CONV: begin
          {bcd, mag} <= {adj, mag} << 1;
          count      <= count + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/signed_sevenseg_scan.sv
// ============================================================================
// signed_sevenseg_scan: signed value to multiplexed 7-seg display driver.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros.  Rev 1.0
// ============================================================================
`default_nettype none

module signed_sevenseg_scan
  import signed_sevenseg_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  value,
  input  logic              load,
  output logic              busy,
  output logic              done,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an
);

  localparam int BCD_W = 4 * (DIGITS - 1);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic               start;
  logic               neg_pend;
  logic [WIDTH-1:0]   mag_in;
  logic               latch;
  logic [BCD_W-1:0]   bcd;
  logic [4*DIGITS-1:0] bcd_pad;
  logic [6:0]         disp      [DIGITS];
  logic [6:0]         disp_next [DIGITS];
  logic [PRE_W-1:0]   presc;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   idx_next;
  logic               presc_tc;

  assign start  = load && !busy;
  // Negation of the most negative value wraps to the correct unsigned magnitude.
  assign mag_in = value[WIDTH-1] ? (~value + WIDTH'(1)) : value;

  always_ff @(posedge clk) begin
    if (rst)        neg_pend <= 1'b0;
    else if (start) neg_pend <= value[WIDTH-1];
  end

  bin2bcd_seq #(
    .WIDTH (WIDTH),
    .BCD_W (BCD_W)
  ) u_bin2bcd (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mag_in (mag_in),
    .busy   (busy),
    .latch  (latch),
    .bcd    (bcd)
  );

  assign bcd_pad = {4'd0, bcd};

`ifdef LEADING_ZERO_BLANK_EN
  int msd_pos;

  always_comb begin
    msd_pos = 0;
    for (int i = 1; i < DIGITS - 1; i++) begin
      if (bcd_pad[4*i +: 4] != 4'd0) msd_pos = i;
    end
    for (int i = 0; i < DIGITS; i++) begin
      disp_next[i] = SEG_BLANK;
      if (i <= msd_pos)                      disp_next[i] = digit_to_seg(bcd_pad[4*i +: 4]);
      else if (i == msd_pos + 1 && neg_pend) disp_next[i] = SEG_MINUS;
    end
  end
`else
  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      disp_next[i] = digit_to_seg(bcd_pad[4*i +: 4]);
    end
    disp_next[DIGITS-1] = neg_pend ? SEG_MINUS : SEG_BLANK;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      done <= 1'b0;
      for (int i = 0; i < DIGITS; i++) disp[i] <= SEG_BLANK;
    end else begin
      done <= latch;
      if (latch) begin
        for (int i = 0; i < DIGITS; i++) disp[i] <= disp_next[i];
      end
    end
  end

  assign presc_tc = (presc == PRE_W'(SCAN_DIV - 1));

  always_comb begin
    idx_next = idx;
    if (presc_tc) idx_next = (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
  end

  // seg/an follow the upcoming index so both switch on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      idx   <= '0;
      seg   <= SEG_BLANK;
      an    <= ~DIGITS'(1);
    end else begin
      presc <= presc_tc ? '0 : presc + 1'b1;
      idx   <= idx_next;
      seg   <= disp[idx_next];
      an    <= ~(DIGITS'(1) << idx_next);
    end
  end

endmodule

`default_nettype wire
